mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be: WIDTH, 16, data width; DEPTH, 64, memory words; ADDR_WIDTH, $clog2(DEPTH), address width; TIMEOUT, 15, maximum WAIT cycles before abort.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset, with these ports (clock and reset first):
- clk_i  in  1  clock, all logic on posedge.
- rst_i  in  1  synchronous active-high reset.
- reqN_valid_i  in  1  request from requester N (N=0,1); held high until reqN_ready_o.
- reqN_wr_rd_en_i  in  1  1=write, 0=read.
- reqN_addr_i  in  ADDR_WIDTH  address.
- reqN_wdata_i  in  WIDTH  write data.
- reqN_ready_o  out  1  one-cycle completion pulse.
- reqN_rdata_o  out  WIDTH  read data, valid while reqN_ready_o=1.
- reqN_err_o  out  1  timeout flag, valid while reqN_ready_o=1.
- mem_valid_o  out  1  memory request strobe.
- mem_wr_rd_en_o  out  1  memory write/read select.
- mem_addr_o  out  ADDR_WIDTH  memory address.
- mem_wdata_o  out  WIDTH  memory write data.
- mem_rdata_i  in  WIDTH  memory read data.
- mem_ready_i  in  1  memory handshake acknowledge.
- busy_o  out  1  high whenever the state is not IDLE.

Function
REQ-003 All outputs SHALL be registered.
REQ-004 The FSM SHALL have the states IDLE, ISSUE, WAIT and DONE.
REQ-005 IDLE: if any reqN_valid_i=1, the block SHALL select one requester, latch its wr_rd_en/addr/wdata and go to ISSUE; otherwise it SHALL stay in IDLE.
REQ-006 Selection SHALL be round-robin on a 1-bit last_grant: with both valid, grant the requester that is not last_grant; with one valid, grant it.
REQ-007 ISSUE: mem_valid_o=1 for exactly one cycle with the latched command; next state WAIT; wait counter cleared.
REQ-008 WAIT: mem_valid_o=0; on mem_ready_i=1 capture mem_rdata_i (reads only) and go to DONE with err=0.
REQ-009 WAIT: if mem_ready_i is still 0 after TIMEOUT cycles, go to DONE with err=1 and rdata=0.
REQ-010 DONE: the granted reqN_ready_o=1 for one cycle, with reqN_rdata_o and reqN_err_o valid; last_grant updated to N; next state IDLE.
REQ-011 In DONE, the non-granted requester SHALL see ready=0, rdata=0 and err=0.
REQ-012 Latency from reqN_valid_i sampled in IDLE to the reqN_ready_o pulse SHALL be 3 cycles when the memory acks in the first WAIT cycle.
REQ-013 Back-to-back requests: a new request sampled in the IDLE cycle after DONE SHALL be accepted; the minimum cycle time is 4 clocks per transaction.
REQ-014 Requests arriving in ISSUE, WAIT or DONE SHALL be held off (no ready) and arbitrated at the next IDLE.
REQ-015 mem_addr_o, mem_wdata_o and mem_wr_rd_en_o SHALL be stable from ISSUE through DONE.
REQ-016 A write SHALL return reqN_rdata_o=0.
REQ-017 The wait counter SHALL be $clog2(TIMEOUT+1) bits and SHALL saturate, never wrap.

Reset
REQ-018 On rst_i=1 at a clock edge the block SHALL clear all outputs to 0, state=IDLE, last_grant=1 (requester 0 wins the first tie) and the wait counter to 0.
REQ-019 Reset asserted mid-transaction (ISSUE/WAIT/DONE) SHALL abort it with no ready pulse; mem_valid_o=0 from the next cycle.
REQ-020 rst_i SHALL take priority over every other input.

Verification
REQ-021 Single write: req0 write addr=5, wdata=16'hA5A5 -> mem_valid_o one cycle; req0_ready_o 3 cycles later, err=0; a follow-up req0 read addr=5 -> req0_rdata_o=16'hA5A5.
REQ-022 Simultaneous requests after reset: req0 read addr=1, req1 read addr=2 -> req0 served first, then req1; mem_addr_o sequence 1 then 2.
REQ-023 Fairness: both requesters held valid for 8 transactions -> grants alternate 0,1,0,1,...; neither requester is granted twice in a row.
REQ-024 Timeout: mem_ready_i tied 0 -> req1_ready_o=1 with req1_err_o=1 and rdata=0 exactly TIMEOUT cycles after entering WAIT.
REQ-025 Reset mid-WAIT: rst_i pulsed during WAIT -> no ready pulse, busy_o=0; the next req0 request completes normally.
REQ-026 Late arrival: req1 asserted during req0 WAIT -> req1 granted in the IDLE after req0 DONE, latency measured from that IDLE.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port memory with a
// bounded wait for the memory handshake; every output comes straight from a flop.
module mem_arbiter #(
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 64,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req0_valid_i,
  input  logic                  req0_wr_rd_en_i,
  input  logic [ADDR_WIDTH-1:0] req0_addr_i,
  input  logic [WIDTH-1:0]      req0_wdata_i,
  output logic                  req0_ready_o,
  output logic [WIDTH-1:0]      req0_rdata_o,
  output logic                  req0_err_o,
  input  logic                  req1_valid_i,
  input  logic                  req1_wr_rd_en_i,
  input  logic [ADDR_WIDTH-1:0] req1_addr_i,
  input  logic [WIDTH-1:0]      req1_wdata_i,
  output logic                  req1_ready_o,
  output logic [WIDTH-1:0]      req1_rdata_o,
  output logic                  req1_err_o,
  output logic                  mem_valid_o,
  output logic                  mem_wr_rd_en_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [WIDTH-1:0]      mem_wdata_o,
  input  logic [WIDTH-1:0]      mem_rdata_i,
  input  logic                  mem_ready_i,
  output logic                  busy_o
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

  state_e             state_q;
  logic               last_grant_q;
  logic               grant_q;
  logic               grant_d;
  logic [CNT_W-1:0]   wait_cnt_q;
  logic               req0_ready_q, req1_ready_q;
  logic               req0_err_q, req1_err_q;
  logic [WIDTH-1:0]   req0_rdata_q, req1_rdata_q;
  logic               mem_valid_q, mem_wr_q, busy_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [WIDTH-1:0]   mem_wdata_q;

  // On a tie the requester that did not win last time gets the grant.
  always_comb begin
    grant_d = req1_valid_i;
    if (req0_valid_i && req1_valid_i) grant_d = ~last_grant_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      wait_cnt_q   <= '0;
      req0_ready_q <= 1'b0;
      req1_ready_q <= 1'b0;
      req0_err_q   <= 1'b0;
      req1_err_q   <= 1'b0;
      req0_rdata_q <= '0;
      req1_rdata_q <= '0;
      mem_valid_q  <= 1'b0;
      mem_wr_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req0_valid_i || req1_valid_i) begin
            grant_q     <= grant_d;
            mem_wr_q    <= grant_d ? req1_wr_rd_en_i : req0_wr_rd_en_i;
            mem_addr_q  <= grant_d ? req1_addr_i     : req0_addr_i;
            mem_wdata_q <= grant_d ? req1_wdata_i    : req0_wdata_i;
            mem_valid_q <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          mem_valid_q <= 1'b0;
          wait_cnt_q  <= '0;
          state_q     <= WAIT;
        end
        WAIT: begin
          if (mem_ready_i) begin
            if (grant_q) begin
              req1_ready_q <= 1'b1;
              req1_rdata_q <= mem_wr_q ? '0 : mem_rdata_i;
            end else begin
              req0_ready_q <= 1'b1;
              req0_rdata_q <= mem_wr_q ? '0 : mem_rdata_i;
            end
            state_q <= DONE;
          end else if (wait_cnt_q == CNT_LAST) begin
            // Abort: the requester gets an error with zero data.
            if (grant_q) begin
              req1_ready_q <= 1'b1;
              req1_err_q   <= 1'b1;
            end else begin
              req0_ready_q <= 1'b1;
              req0_err_q   <= 1'b1;
            end
            state_q <= DONE;
          end else if (wait_cnt_q != CNT_MAX) begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        DONE: begin
          req0_ready_q <= 1'b0;
          req1_ready_q <= 1'b0;
          req0_err_q   <= 1'b0;
          req1_err_q   <= 1'b0;
          req0_rdata_q <= '0;
          req1_rdata_q <= '0;
          last_grant_q <= grant_q;
          busy_q       <= 1'b0;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req0_ready_o   = req0_ready_q;
  assign req1_ready_o   = req1_ready_q;
  assign req0_err_o     = req0_err_q;
  assign req1_err_o     = req1_err_q;
  assign req0_rdata_o   = req0_rdata_q;
  assign req1_rdata_o   = req1_rdata_q;
  assign mem_valid_o    = mem_valid_q;
  assign mem_wr_rd_en_o = mem_wr_q;
  assign mem_addr_o     = mem_addr_q;
  assign mem_wdata_o    = mem_wdata_q;
  assign busy_o         = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter: the bench plays both requesters and the
// memory, and checks grants, data, latency and timeout against hand-worked values.
module tb_mem_arbiter;

  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid_i, req0_wr_rd_en_i, req1_valid_i, req1_wr_rd_en_i;
  logic [5:0]  req0_addr_i, req1_addr_i;
  logic [15:0] req0_wdata_i, req1_wdata_i;
  logic        req0_ready_o, req0_err_o, req1_ready_o, req1_err_o;
  logic [15:0] req0_rdata_o, req1_rdata_o;
  logic        mem_valid_o, mem_wr_rd_en_o, mem_ready_i, busy_o;
  logic [5:0]  mem_addr_o;
  logic [15:0] mem_wdata_o, mem_rdata_i;

  logic [15:0] tbMem [64];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.WIDTH(16), .DEPTH(64), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk), .rst_i(rst),
    .req0_valid_i(req0_valid_i), .req0_wr_rd_en_i(req0_wr_rd_en_i),
    .req0_addr_i(req0_addr_i), .req0_wdata_i(req0_wdata_i),
    .req0_ready_o(req0_ready_o), .req0_rdata_o(req0_rdata_o), .req0_err_o(req0_err_o),
    .req1_valid_i(req1_valid_i), .req1_wr_rd_en_i(req1_wr_rd_en_i),
    .req1_addr_i(req1_addr_i), .req1_wdata_i(req1_wdata_i),
    .req1_ready_o(req1_ready_o), .req1_rdata_o(req1_rdata_o), .req1_err_o(req1_err_o),
    .mem_valid_o(mem_valid_o), .mem_wr_rd_en_o(mem_wr_rd_en_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i), .mem_ready_i(mem_ready_i), .busy_o(busy_o)
  );

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    req0_valid_i = 0; req1_valid_i = 0; mem_ready_i = 0; mem_rdata_i = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Runs negedge by negedge until a requester sees ready, acting as the memory.
  // ackDelay < 0 means the memory never answers; lateAt raises req1_valid_i at that cycle.
  task automatic runTxn(input int ackDelay, input int lateAt,
                        output int who, output logic [15:0] rd, output logic er,
                        output int cycles, output logic [5:0] addrSeen, output logic wrSeen,
                        output int mvCount, output bit stableOk, output bit otherOk);
    int vAt;
    who = -1; rd = '0; er = 1'b0; cycles = 0; addrSeen = '0; wrSeen = 1'b0;
    mvCount = 0; stableOk = 1; otherOk = 1; vAt = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      cycles = c;
      if (mem_valid_o) begin
        mvCount++;
        if (vAt < 0) begin
          vAt = c; addrSeen = mem_addr_o; wrSeen = mem_wr_rd_en_o;
          if (mem_wr_rd_en_o) tbMem[mem_addr_o] = mem_wdata_o;
        end
      end
      if (vAt >= 0 && (mem_addr_o !== addrSeen || mem_wr_rd_en_o !== wrSeen)) stableOk = 0;
      if (req0_ready_o) begin
        who = 0; rd = req0_rdata_o; er = req0_err_o;
        otherOk = (req1_ready_o === 1'b0 && req1_err_o === 1'b0 && req1_rdata_o === 16'h0);
        req0_valid_i = 1'b0;
        break;
      end
      if (req1_ready_o) begin
        who = 1; rd = req1_rdata_o; er = req1_err_o;
        otherOk = (req0_ready_o === 1'b0 && req0_err_o === 1'b0 && req0_rdata_o === 16'h0);
        req1_valid_i = 1'b0;
        break;
      end
      if (c == lateAt) req1_valid_i = 1'b1;
      mem_ready_i = (ackDelay >= 0 && vAt >= 0 && c == vAt + 1 + ackDelay);
      mem_rdata_i = mem_ready_i ? tbMem[addrSeen] : 16'h0;
    end
    mem_ready_i = 1'b0;
    mem_rdata_i = '0;
  endtask

  task automatic test_reset();
    logic [15:0] got [10];
    string nm [10];
    @(negedge clk);
    rst = 1'b1;
    req0_valid_i = 1; req0_wr_rd_en_i = 1; req0_addr_i = 6'd7; req0_wdata_i = 16'hFFFF;
    req1_valid_i = 1; mem_ready_i = 1; mem_rdata_i = 16'hBEEF;
    repeat (3) @(negedge clk);
    got = '{16'(mem_valid_o), 16'(busy_o), 16'(req0_ready_o), 16'(req1_ready_o),
            16'(mem_addr_o), mem_wdata_o, 16'(mem_wr_rd_en_o), req0_rdata_o,
            16'(req0_err_o), req1_rdata_o};
    nm  = '{"rst_mem_valid", "rst_busy", "rst_ready0", "rst_ready1", "rst_addr",
            "rst_wdata", "rst_wr", "rst_rdata0", "rst_err0", "rst_rdata1"};
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (got[i] !== 16'h0) begin
        errors++; $display("[TB] FAIL %s: got %0h want 0", nm[i], got[i]);
      end
    end
    req0_valid_i = 0; req1_valid_i = 0; mem_ready_i = 0; mem_rdata_i = '0;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy_o !== 1'b0) begin
      errors++; $display("[TB] FAIL idle_busy: got %0b want 0", busy_o);
    end
  endtask

  task automatic test_single_write();
    int who, cyc, mv; logic [15:0] rd; logic er, wr; logic [5:0] a; bit st, ot;
    doReset();
    req0_wr_rd_en_i = 1; req0_addr_i = 6'd5; req0_wdata_i = 16'hA5A5; req0_valid_i = 1;
    runTxn(0, -1, who, rd, er, cyc, a, wr, mv, st, ot);
    checks++; if (who !== 0) begin errors++; $display("[TB] FAIL wr_who: got %0d want 0", who); end
    checks++; if (cyc !== 3) begin errors++; $display("[TB] FAIL wr_latency: got %0d want 3", cyc); end
    checks++; if (er !== 1'b0) begin errors++; $display("[TB] FAIL wr_err: got %0b want 0", er); end
    checks++; if (rd !== 16'h0) begin errors++; $display("[TB] FAIL wr_rdata: got %0h want 0", rd); end
    checks++; if (mv !== 1) begin errors++; $display("[TB] FAIL wr_mem_valid_len: got %0d want 1", mv); end
    checks++; if (a !== 6'd5 || wr !== 1'b1) begin errors++; $display("[TB] FAIL wr_cmd: got addr %0d wr %0b want 5 1", a, wr); end
    checks++; if (st !== 1'b1) begin errors++; $display("[TB] FAIL wr_stable: got %0b want 1", st); end
    req0_wr_rd_en_i = 0; req0_addr_i = 6'd5; req0_valid_i = 1;
    runTxn(0, -1, who, rd, er, cyc, a, wr, mv, st, ot);
    checks++; if (who !== 0) begin errors++; $display("[TB] FAIL rd_who: got %0d want 0", who); end
    checks++; if (rd !== 16'hA5A5) begin errors++; $display("[TB] FAIL rd_rdata: got %0h want a5a5", rd); end
    checks++; if (cyc !== 4) begin errors++; $display("[TB] FAIL rd_back_to_back: got %0d want 4", cyc); end
  endtask

  task automatic test_simultaneous();
    int who, cyc, mv; logic [15:0] rd; logic er, wr; logic [5:0] a; bit st, ot;
    doReset();
    req0_wr_rd_en_i = 0; req0_addr_i = 6'd1; req0_valid_i = 1;
    req1_wr_rd_en_i = 0; req1_addr_i = 6'd2; req1_valid_i = 1;
    runTxn(0, -1, who, rd, er, cyc, a, wr, mv, st, ot);
    checks++; if (who !== 0 || a !== 6'd1) begin errors++; $display("[TB] FAIL sim_first: got who %0d addr %0d want 0 1", who, a); end
    checks++; if (rd !== 16'h1001) begin errors++; $display("[TB] FAIL sim_rdata0: got %0h want 1001", rd); end
    checks++; if (ot !== 1'b1) begin errors++; $display("[TB] FAIL sim_other0: got %0b want 1", ot); end
    runTxn(0, -1, who, rd, er, cyc, a, wr, mv, st, ot);
    checks++; if (who !== 1 || a !== 6'd2) begin errors++; $display("[TB] FAIL sim_second: got who %0d addr %0d want 1 2", who, a); end
    checks++; if (rd !== 16'h1002) begin errors++; $display("[TB] FAIL sim_rdata1: got %0h want 1002", rd); end
    checks++; if (ot !== 1'b1) begin errors++; $display("[TB] FAIL sim_other1: got %0b want 1", ot); end
  endtask

  task automatic test_fairness();
    int who, cyc, mv; logic [15:0] rd; logic er, wr; logic [5:0] a; bit st, ot;
    doReset();
    req0_wr_rd_en_i = 0; req0_addr_i = 6'd10; req0_valid_i = 1;
    req1_wr_rd_en_i = 0; req1_addr_i = 6'd20; req1_valid_i = 1;
    for (int i = 0; i < 8; i++) begin
      runTxn(0, -1, who, rd, er, cyc, a, wr, mv, st, ot);
      checks++;
      if (who !== i % 2) begin errors++; $display("[TB] FAIL fair_grant%0d: got %0d want %0d", i, who, i % 2); end
      checks++;
      if (cyc !== ((i == 0) ? 3 : 4)) begin errors++; $display("[TB] FAIL fair_cycle%0d: got %0d want %0d", i, cyc, (i == 0) ? 3 : 4); end
      if (who == 0) req0_valid_i = 1; else if (who == 1) req1_valid_i = 1;
    end
    req0_valid_i = 0; req1_valid_i = 0;
  endtask

  task automatic test_timeout();
    int who, cyc, mv; logic [15:0] rd; logic er, wr; logic [5:0] a; bit st, ot;
    doReset();
    req1_wr_rd_en_i = 0; req1_addr_i = 6'd3; req1_valid_i = 1;
    runTxn(-1, -1, who, rd, er, cyc, a, wr, mv, st, ot);
    checks++; if (who !== 1) begin errors++; $display("[TB] FAIL to_who: got %0d want 1", who); end
    checks++; if (er !== 1'b1) begin errors++; $display("[TB] FAIL to_err: got %0b want 1", er); end
    checks++; if (rd !== 16'h0) begin errors++; $display("[TB] FAIL to_rdata: got %0h want 0", rd); end
    checks++; if (cyc !== 2 + TIMEOUT) begin errors++; $display("[TB] FAIL to_latency: got %0d want %0d", cyc, 2 + TIMEOUT); end
    checks++; if (ot !== 1'b1) begin errors++; $display("[TB] FAIL to_other: got %0b want 1", ot); end
  endtask

  task automatic test_reset_mid_wait();
    int who, cyc, mv; logic [15:0] rd; logic er, wr; logic [5:0] a; bit st, ot;
    doReset();
    req0_wr_rd_en_i = 0; req0_addr_i = 6'd6; req0_valid_i = 1;
    @(negedge clk);
    checks++; if (mem_valid_o !== 1'b1) begin errors++; $display("[TB] FAIL mid_issue: got %0b want 1", mem_valid_o); end
    @(negedge clk);
    checks++; if (busy_o !== 1'b1 || mem_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL mid_wait: got busy %0b valid %0b want 1 0", busy_o, mem_valid_o); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (req0_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL mid_no_ready: got %0b want 0", req0_ready_o); end
    checks++; if (busy_o !== 1'b0 || mem_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL mid_abort: got busy %0b valid %0b want 0 0", busy_o, mem_valid_o); end
    rst = 1'b0;
    runTxn(0, -1, who, rd, er, cyc, a, wr, mv, st, ot);
    checks++; if (who !== 0 || cyc !== 3) begin errors++; $display("[TB] FAIL mid_retry: got who %0d cyc %0d want 0 3", who, cyc); end
    checks++; if (rd !== 16'h1006 || er !== 1'b0) begin errors++; $display("[TB] FAIL mid_rdata: got %0h err %0b want 1006 0", rd, er); end
  endtask

  task automatic test_late_arrival();
    int who, cyc, mv; logic [15:0] rd; logic er, wr; logic [5:0] a; bit st, ot;
    doReset();
    req0_wr_rd_en_i = 0; req0_addr_i = 6'd7; req0_valid_i = 1;
    req1_wr_rd_en_i = 0; req1_addr_i = 6'd8; req1_valid_i = 0;
    runTxn(0, 2, who, rd, er, cyc, a, wr, mv, st, ot);
    checks++; if (who !== 0 || cyc !== 3) begin errors++; $display("[TB] FAIL late_first: got who %0d cyc %0d want 0 3", who, cyc); end
    checks++; if (rd !== 16'h1007 || ot !== 1'b1) begin errors++; $display("[TB] FAIL late_first_data: got %0h other %0b want 1007 1", rd, ot); end
    runTxn(0, -1, who, rd, er, cyc, a, wr, mv, st, ot);
    checks++; if (who !== 1 || cyc !== 4) begin errors++; $display("[TB] FAIL late_second: got who %0d cyc %0d want 1 4", who, cyc); end
    checks++; if (rd !== 16'h1008 || a !== 6'd8) begin errors++; $display("[TB] FAIL late_second_data: got %0h addr %0d want 1008 8", rd, a); end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) tbMem[i] = 16'h1000 + 16'(i);
    rst = 1'b1;
    req0_valid_i = 0; req0_wr_rd_en_i = 0; req0_addr_i = '0; req0_wdata_i = '0;
    req1_valid_i = 0; req1_wr_rd_en_i = 0; req1_addr_i = '0; req1_wdata_i = '0;
    mem_ready_i = 0; mem_rdata_i = '0;
    $display("[TB] starting mem_arbiter tests");
    test_reset();
    test_single_write();
    test_simultaneous();
    test_fairness();
    test_timeout();
    test_reset_mid_wait();
    test_late_arrival();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
